// File: rtl/bsw_pkg.sv
// -----------------------------------------------------------------------------
// bsw_pkg
// Shared definitions for the banded Smith-Waterman systolic array controller:
// controller state encoding, the scoring constants used by the PE array and
// the width of the H (cell score) values returned by each PE.
// -----------------------------------------------------------------------------
package bsw_pkg;

   // Width of the H score produced by every PE.
   localparam int HW = 7;

   // Scoring scheme used by the PE array (affine gaps).
   localparam int SC_MATCH    = 2;
   localparam int SC_MISMATCH = -1;
   localparam int SC_GAP_OPEN = -2;
   localparam int SC_GAP_EXT  = -1;
   // Value the PE array loads into its I/D registers when idle.
   localparam int SC_ID_IDLE  = -128;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD_Q = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } bsw_state_e;

endpackage

// File: rtl/bsw_array_ctrl_if.sv
// -----------------------------------------------------------------------------
// bsw_array_ctrl_if
// Base stream feeding the controller: query bases first, then reference
// bases, one 2-bit base per in_valid & in_ready beat.
//   in_valid : source has a base on in_base
//   in_base  : 2-bit nucleotide code
//   in_ready : controller accepts the base this cycle
// Modports: master = stream source, slave = controller.
// -----------------------------------------------------------------------------
interface bsw_array_ctrl_if;

   logic       in_valid;
   logic [1:0] in_base;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_base,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_base,
      output in_ready
   );

endinterface

// File: rtl/bsw_max_tracker.sv
// -----------------------------------------------------------------------------
// bsw_max_tracker
// Combinational running-maximum search across the NPE PE scores of one step.
// A PE score replaces the current best only when strictly greater, so on ties
// the incumbent best (an earlier step) wins, and within a step the lowest
// PE index wins.
// Ports:
//   i_valid [NPE]     : PE k holds a valid cell this step
//   i_h     [HW*NPE]  : H of PE k in bits [HW*k +: HW]
//   i_best  [HW]      : best score so far
//   o_hit             : some valid PE beats i_best
//   o_score [HW]      : new best score (equals i_best when no hit)
//   o_idx   [LW]      : PE index of the new best
// -----------------------------------------------------------------------------
module bsw_max_tracker
   import bsw_pkg::*;
#(
   parameter int NPE = 8,
   parameter int LW  = 8
) (
   input  logic [NPE-1:0]    i_valid,
   input  logic [HW*NPE-1:0] i_h,
   input  logic [HW-1:0]     i_best,
   output logic              o_hit,
   output logic [HW-1:0]     o_score,
   output logic [LW-1:0]     o_idx
);

   // NOTE: every output gets a default before the loop so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      o_hit   = 1'b0;
      o_score = i_best;
      o_idx   = '0;
      // NOTE: blocking assignments here so each iteration compares against the
      // value left by the previous one; this is a priority chain, not state.
      for (int k = 0; k < NPE; k++) begin
         if (i_valid[k] && (i_h[HW*k +: HW] > o_score)) begin
            o_hit   = 1'b1;
            o_score = i_h[HW*k +: HW];
            o_idx   = LW'(k);
         end
      end
   end

endmodule

// File: rtl/bsw_array_ctrl.sv
// -----------------------------------------------------------------------------
// bsw_array_ctrl
// Controller for a linear systolic Smith-Waterman array of NPE PEs. PE k holds
// query base k; reference bases are shifted through the array one PE per
// step, so reference base j sits in PE k at step j+k. The controller loads the
// query, streams the reference, gates the array with step_en and tracks the
// best H seen over the whole job.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, q_len, r_len : job request (honoured in IDLE only)
//   base_if (slave)     : base stream in_valid / in_base / in_ready
//   pe_valid [NPE]      : PE k computes a real cell this step
//   pe_q, pe_r [2*NPE]  : query / reference base at PE k, bits [2k+1:2k]
//   step_en             : array advance enable
//   pe_h [HW*NPE]       : H output of PE k
//   busy, done          : job in progress / one-cycle completion pulse
//   best_score/row/col  : best H, its PE index and its reference index
// -----------------------------------------------------------------------------
module bsw_array_ctrl
   import bsw_pkg::*;
#(
   parameter int NPE = 8,
   parameter int LW  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LW-1:0]     q_len,
   input  logic [LW-1:0]     r_len,
   bsw_array_ctrl_if.slave   base_if,
   output logic [NPE-1:0]    pe_valid,
   output logic [2*NPE-1:0]  pe_q,
   output logic [2*NPE-1:0]  pe_r,
   output logic              step_en,
   input  logic [HW*NPE-1:0] pe_h,
   output logic              busy,
   output logic              done,
   output logic [HW-1:0]     best_score,
   output logic [LW-1:0]     best_row,
   output logic [LW-1:0]     best_col
);

   // One extra bit so r_len+q_len-1 steps never wrap the step counter.
   localparam int TW = LW + 1;

   bsw_state_e       r_state;
   bsw_state_e       w_next_state;
   logic [LW-1:0]    r_q_len;
   logic [LW-1:0]    r_r_len;
   // Beat index in LOAD_Q, step index t in RUN.
   logic [TW-1:0]    r_t;
   logic [2*NPE-1:0] r_pe_q;
   logic [2*NPE-1:0] r_pe_r;
   logic [HW-1:0]    r_best_score;
   logic [LW-1:0]    r_best_row;
   logic [LW-1:0]    r_best_col;

   logic             w_run;
   logic             w_ref_left;
   logic             w_step_en;
   logic             w_beat;
   logic             w_last_beat;
   logic             w_last_step;
   logic [TW-1:0]    w_last_t;
   logic [1:0]       w_shift_in;
   logic [NPE-1:0]   w_pe_valid;
   logic             w_hit;
   logic [HW-1:0]    w_max_score;
   logic [LW-1:0]    w_max_idx;

   assign w_run       = (r_state == ST_RUN);
   assign w_ref_left  = (r_t < {1'b0, r_r_len});
   assign w_step_en   = w_run && (!w_ref_left || base_if.in_valid);
   assign w_beat      = (r_state == ST_LOAD_Q) && base_if.in_valid;
   assign w_last_beat = w_beat && (r_t == ({1'b0, r_q_len} - TW'(1)));
   assign w_last_t    = {1'b0, r_r_len} + {1'b0, r_q_len} - TW'(2);
   assign w_last_step = w_step_en && (r_t == w_last_t);
   // Once the reference is exhausted, zeros flush the remaining bases through.
   assign w_shift_in  = w_ref_left ? base_if.in_base : 2'b00;

   // The cell PE k works on during step t is (k, t-k); it is real only when
   // k is a loaded query slot and t-k names an existing reference base.
   always_comb begin
      w_pe_valid = '0;
      for (int k = 0; k < NPE; k++) begin
         if (w_step_en && (LW'(k) < r_q_len) && (r_t >= TW'(k)) &&
             ((r_t - TW'(k)) < {1'b0, r_r_len}))
            w_pe_valid[k] = 1'b1;
      end
   end

   bsw_max_tracker #(
      .NPE (NPE),
      .LW  (LW)
   ) u_max_tracker (
      .i_valid (w_pe_valid),
      .i_h     (pe_h),
      .i_best  (r_best_score),
      .o_hit   (w_hit),
      .o_score (w_max_score),
      .o_idx   (w_max_idx)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start)
               w_next_state = ((q_len == '0) || (r_len == '0)) ? ST_DONE : ST_LOAD_Q;
         end
         ST_LOAD_Q: if (w_last_beat) w_next_state = ST_RUN;
         ST_RUN:    if (w_last_step) w_next_state = ST_DONE;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: the query and reference shift registers are reset along with the
   // control state because they drive outputs that must read 0 in reset; they
   // are a handful of flops, not a RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q_len      <= '0;
         r_r_len      <= '0;
         r_t          <= '0;
         r_pe_q       <= '0;
         r_pe_r       <= '0;
         r_best_score <= '0;
         r_best_row   <= '0;
         r_best_col   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_q_len      <= q_len;
                  r_r_len      <= r_len;
                  r_t          <= '0;
                  r_pe_q       <= '0;
                  r_pe_r       <= '0;
                  r_best_score <= '0;
                  r_best_row   <= '0;
                  r_best_col   <= '0;
               end
            end
            ST_LOAD_Q: begin
               if (w_beat) begin
                  for (int k = 0; k < NPE; k++) begin
                     if (r_t == TW'(k)) r_pe_q[2*k +: 2] <= base_if.in_base;
                  end
                  // Counter restarts at 0 to become the RUN step index.
                  r_t <= w_last_beat ? '0 : r_t + TW'(1);
               end
            end
            ST_RUN: begin
               if (w_step_en) begin
                  r_pe_r <= {r_pe_r[2*NPE-3:0], w_shift_in};
                  r_t    <= r_t + TW'(1);
                  if (w_hit) begin
                     r_best_score <= w_max_score;
                     r_best_row   <= w_max_idx;
                     r_best_col   <= LW'(r_t - {1'b0, w_max_idx});
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign base_if.in_ready = (r_state == ST_LOAD_Q) || (w_run && w_ref_left);
   assign step_en          = w_step_en;
   assign pe_valid         = w_pe_valid;
   assign pe_q             = r_pe_q;
   assign pe_r             = r_pe_r;
   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);
   assign best_score       = r_best_score;
   assign best_row         = r_best_row;
   assign best_col         = r_best_col;

endmodule

// File: tb/tb_bsw_array_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bsw_array_ctrl
// Directed bench for bsw_array_ctrl. pe_h is driven by a small affine-gap
// Smith-Waterman model (or a forced table) indexed by the bench's own step
// count; expected best_* values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_bsw_array_ctrl;
   import bsw_pkg::*;

   localparam int NPE = 8;
   localparam int LW  = 8;
   localparam int RMAX = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              start;
   logic [LW-1:0]     q_len;
   logic [LW-1:0]     r_len;
   logic [NPE-1:0]    pe_valid;
   logic [2*NPE-1:0]  pe_q;
   logic [2*NPE-1:0]  pe_r;
   logic              step_en;
   logic [HW*NPE-1:0] pe_h;
   logic              busy;
   logic              done;
   logic [HW-1:0]     best_score;
   logic [LW-1:0]     best_row;
   logic [LW-1:0]     best_col;

   bsw_array_ctrl_if base_if ();

   bsw_array_ctrl #(
      .NPE (NPE),
      .LW  (LW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .q_len      (q_len),
      .r_len      (r_len),
      .base_if    (base_if),
      .pe_valid   (pe_valid),
      .pe_q       (pe_q),
      .pe_r       (pe_r),
      .step_en    (step_en),
      .pe_h       (pe_h),
      .busy       (busy),
      .done       (done),
      .best_score (best_score),
      .best_row   (best_row),
      .best_col   (best_col)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Stimulus sequences (A=0 C=1 G=2 T=3) and the PE score model.
   logic [1:0] tq [NPE];
   logic [1:0] tr [RMAX];
   int         hm [NPE][RMAX];
   bit         forced_mode = 1'b0;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic build_h(input int ql, input int rl);
      int e [NPE][RMAX];
      int f [NPE][RMAX];
      for (int i = 0; i < ql; i++) begin
         for (int j = 0; j < rl; j++) begin
            int hd, sc, ev, fv;
            hd = (i > 0 && j > 0) ? hm[i-1][j-1] : 0;
            sc = (tq[i] == tr[j]) ? SC_MATCH : SC_MISMATCH;
            ev = (j > 0) ? max2(hm[i][j-1] + SC_GAP_OPEN, e[i][j-1] + SC_GAP_EXT) : -1000;
            fv = (i > 0) ? max2(hm[i-1][j] + SC_GAP_OPEN, f[i-1][j] + SC_GAP_EXT) : -1000;
            e[i][j]  = ev;
            f[i][j]  = fv;
            hm[i][j] = max2(max2(0, hd + sc), max2(ev, fv));
         end
      end
   endtask

   // H presented by PE k at step t (cell k, t-k).
   function automatic logic [HW-1:0] cell_h(input int k, input int t);
      if (forced_mode) begin
         if (t == 3 && k == 1) return HW'(4);
         if (t == 5 && (k == 2 || k == 5)) return HW'(6);
         if (t == 6 && k == 6) return HW'(5);
         if (t == 7 && k == 4) return HW'(6);
         return '0;
      end
      return HW'(hm[k][t-k]);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_pe_valid"}, pe_valid, 0);
      check({tag, "_pe_q"}, pe_q, 0);
      check({tag, "_pe_r"}, pe_r, 0);
      check({tag, "_step_en"}, step_en, 0);
      check({tag, "_in_ready"}, base_if.in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_best_score"}, best_score, 0);
      check({tag, "_best_row"}, best_row, 0);
      check({tag, "_best_col"}, best_col, 0);
   endtask

   // One job: start, query load, reference run, done. Optional stall at step
   // stall_t for stall_n cycles, reset at step rst_t, stray start at inject_t.
   task automatic run_job(input string tag, input int ql, input int rl,
                          input int stall_t, input int stall_n,
                          input int rst_t, input int inject_t,
                          input int exp_score, input int exp_row, input int exp_col);
      int s, stalls_done, steps_seen, bad;
      logic stall;
      logic [NPE-1:0]   exp_pv;
      logic [2*NPE-1:0] exp_pr;
      logic [2*NPE-1:0] exp_pq;
      build_h(ql, rl);

      @(negedge clk);
      start = 1'b1;
      q_len = LW'(ql);
      r_len = LW'(rl);
      base_if.in_valid = 1'b0;
      base_if.in_base  = 2'b00;
      pe_h = '1;
      #1 check({tag, "_idle_busy"}, busy, 0);

      @(negedge clk);
      start = 1'b0;
      if (ql == 0 || rl == 0) begin
         #1;
         check({tag, "_zero_done"}, done, 1);
         check({tag, "_zero_busy"}, busy, 1);
         check({tag, "_zero_in_ready"}, base_if.in_ready, 0);
         check({tag, "_zero_best_score"}, best_score, 0);
         check({tag, "_zero_best_row"}, best_row, 0);
         check({tag, "_zero_best_col"}, best_col, 0);
         @(negedge clk);
         #1;
         check({tag, "_zero_done_clear"}, done, 0);
         check({tag, "_zero_idle"}, busy, 0);
         return;
      end

      bad = 0;
      for (int n = 0; n < ql; n++) begin
         base_if.in_valid = 1'b1;
         base_if.in_base  = tq[n];
         #1;
         if (base_if.in_ready !== 1'b1 || step_en !== 1'b0 || busy !== 1'b1 ||
             pe_valid !== '0 || done !== 1'b0) bad++;
         @(negedge clk);
      end
      check({tag, "_load_trace"}, bad, 0);

      exp_pq = '0;
      for (int k = 0; k < ql; k++) exp_pq[2*k +: 2] = tq[k];

      s = 0;
      stalls_done = 0;
      steps_seen = 0;
      bad = 0;
      while (s < ql + rl - 1) begin
         stall = (s == stall_t) && (stalls_done < stall_n);
         base_if.in_valid = !stall && (s < rl);
         base_if.in_base  = (s < rl) ? tr[s] : 2'b11;
         for (int k = 0; k < NPE; k++) begin
            int j;
            j = s - 1 - k;
            exp_pv[k] = !stall && (k < ql) && (s - k >= 0) && (s - k < rl);
            pe_h[HW*k +: HW] = exp_pv[k] ? cell_h(k, s) : '1;
            exp_pr[2*k +: 2] = (j >= 0 && j < rl) ? tr[j] : 2'b00;
         end
         if (s == inject_t && stalls_done == 0) begin
            start = 1'b1;
            q_len = LW'(2);
            r_len = LW'(1);
         end
         if (s == rst_t) begin
            rst_n = 1'b0;
            #1 check_all_zero({tag, "_async"});
            @(negedge clk);
            rst_n = 1'b1;
            base_if.in_valid = 1'b0;
            pe_h = '1;
            return;
         end
         #1;
         if (s == 0) check({tag, "_pe_q"}, pe_q, exp_pq);
         if (step_en !== !stall) bad++;
         if (pe_valid !== exp_pv) bad++;
         if (base_if.in_ready !== (s < rl)) bad++;
         if (pe_r !== exp_pr) bad++;
         if (done !== 1'b0 || busy !== 1'b1) bad++;
         if (step_en === 1'b1) steps_seen++;
         if (stall) stalls_done++;
         else s++;
         @(negedge clk);
         start = 1'b0;
      end

      base_if.in_valid = 1'b0;
      pe_h = '1;
      #1;
      check({tag, "_run_trace"}, bad, 0);
      check({tag, "_steps"}, steps_seen, ql + rl - 1);
      check({tag, "_done"}, done, 1);
      check({tag, "_done_busy"}, busy, 1);
      check({tag, "_done_in_ready"}, base_if.in_ready, 0);
      check({tag, "_done_step_en"}, step_en, 0);
      @(negedge clk);
      #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_best_score"}, best_score, exp_score);
      check({tag, "_best_row"}, best_row, exp_row);
      check({tag, "_best_col"}, best_col, exp_col);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      q_len = '0;
      r_len = '0;
      base_if.in_valid = 1'b0;
      base_if.in_base  = 2'b00;
      pe_h = '1;
      #2 rst_n = 1'b0;
      #1 check_all_zero("por");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Query ACGTACGT, reference CGT: best 6 at PE3, ref 2 (step 5).
      tq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      tr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      run_job("stall", 8, 3, 1, 2, -1, -1, 6, 3, 2);
      run_job("nostall", 8, 3, -1, 0, -1, -1, 6, 3, 2);

      // Query ACGT, reference ACGT: full diagonal, best 8 at PE3, ref 3.
      tq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      tr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      run_job("acgt", 4, 4, -1, 0, -1, -1, 8, 3, 3);

      run_job("q0", 0, 5, -1, 0, -1, -1, 0, 0, 0);
      run_job("r0", 3, 0, -1, 0, -1, -1, 0, 0, 0);

      // Forced scores: 4 @ (t3,PE1), 6 @ (t5,PE2) and (t5,PE5), 5 @ (t6,PE6),
      // 6 @ (t7,PE4) -> best 6 at PE2, ref 5-2 = 3.
      forced_mode = 1'b1;
      tq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
      run_job("forced", 8, 4, -1, 0, -1, -1, 6, 2, 3);
      forced_mode = 1'b0;

      tq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
      run_job("rst", 4, 4, -1, 0, 3, -1, 0, 0, 0);
      run_job("inject", 4, 4, -1, 0, -1, 2, 8, 3, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
